// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: issues fetch requests to a
// 1-cycle synchronous instruction memory and queues {pc, instr} for decode.
module fetch_queue #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic               i_instr_req,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic               o_mem_en,
  input  logic [INSTR_W-1:0] i_mem_rdata,
  output logic               o_stall,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  input  logic               i_de_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Handshakes: a fetch request is accepted when i_instr_req && !o_stall;
  // decode consumes the head when o_valid && i_de_ready. Neither side may
  // assume a transfer on any other combination.

  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               pend;
  logic [ADDR_W-1:0]  pend_pc;
  logic [ADDR_W-1:0]  pc_store    [DEPTH];
  logic [INSTR_W-1:0] instr_store [DEPTH];

  logic [CNT_W:0]     occupancy;
  logic               acc;
  logic               enq;
  logic               deq;

  // Stall counts the in-flight response so a reserved slot always exists.
  assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, pend};
  assign o_stall    = (occupancy >= DEPTH_OCC);

  assign acc        = i_instr_req && !o_stall && clr_n;
  assign o_mem_en   = acc;
  assign o_mem_addr = i_pc;

  assign o_valid    = (count != '0) && !flush;
  assign enq        = pend && !flush;
  assign deq        = o_valid && i_de_ready;

  always_comb begin
    o_pc    = '0;
    o_instr = '0;
    if (o_valid) begin
      o_pc    = pc_store[rd_ptr];
      o_instr = instr_store[rd_ptr];
    end
  end

  // The request accepted during a flush is the branch target, so pend
  // follows acc regardless of flush.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pend    <= 1'b0;
      pend_pc <= '0;
    end else begin
      pend <= acc;
      if (acc) begin
        pend_pc <= i_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + CNT_W'(enq) - CNT_W'(deq);
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_store[wr_ptr]    <= pend_pc;
      instr_store[wr_ptr] <= i_mem_rdata;
    end
  end

`ifndef SYNTHESIS
  no_overflow: assert property (@(posedge clk) disable iff (!clr_n)
    !(enq && (count == DEPTH_CNT)));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-level reference model,
// with a memory model answering one cycle after each accepted request.
module tb_fetch_queue;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic               clk;
  logic               clr_n;
  logic               flush;
  logic [ADDR_W-1:0]  i_pc;
  logic               i_instr_req;
  logic [ADDR_W-1:0]  o_mem_addr;
  logic               o_mem_en;
  logic [INSTR_W-1:0] i_mem_rdata;
  logic               o_stall;
  logic               o_valid;
  logic [ADDR_W-1:0]  o_pc;
  logic [INSTR_W-1:0] o_instr;
  logic               i_de_ready;

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .flush       (flush),
    .i_pc        (i_pc),
    .i_instr_req (i_instr_req),
    .o_mem_addr  (o_mem_addr),
    .o_mem_en    (o_mem_en),
    .i_mem_rdata (i_mem_rdata),
    .o_stall     (o_stall),
    .o_valid     (o_valid),
    .o_pc        (o_pc),
    .o_instr     (o_instr),
    .i_de_ready  (i_de_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: buffered entries as {pc, instr}, plus the in-flight fetch
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];
  logic                      m_pend;
  logic [ADDR_W-1:0]         m_pend_pc;
  logic                      m_acc;

  // memory model response state
  logic                      resp_v;
  logic [INSTR_W-1:0]        resp_data;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver: called just after a negedge. Drives inputs, checks the DUT's
  // combinational view against the model, then advances across one posedge.
  task automatic cycle(input logic req, input logic rdy, input logic fl,
                       input logic [ADDR_W-1:0] pc);
    int occ;
    logic exp_stall, exp_valid;
    logic [ADDR_W+INSTR_W-1:0] head;
    i_instr_req = req;
    i_de_ready  = rdy;
    flush       = fl;
    i_pc        = pc;
    i_mem_rdata = resp_v ? resp_data : INSTR_W'($urandom);
    #1;
    if (!clr_n) begin
      exp_q.delete();
      m_pend    = 1'b0;
      m_pend_pc = '0;
    end
    occ       = exp_q.size() + int'(m_pend);
    exp_stall = clr_n && (occ >= DEPTH);
    m_acc     = clr_n && req && !exp_stall;
    exp_valid = (exp_q.size() != 0) && !fl;
    head      = exp_valid ? exp_q[0] : '0;
    check("o_stall",    64'(o_stall),    64'(exp_stall));
    check("o_mem_en",   64'(o_mem_en),   64'(m_acc));
    check("o_mem_addr", 64'(o_mem_addr), 64'(pc));
    check("o_valid",    64'(o_valid),    64'(exp_valid));
    check("o_pc",       64'(o_pc),       64'(head[ADDR_W+INSTR_W-1:INSTR_W]));
    check("o_instr",    64'(o_instr),    64'(head[INSTR_W-1:0]));
    if (clr_n) begin
      if (fl) begin
        exp_q.delete();
      end else begin
        if (exp_valid && rdy) void'(exp_q.pop_front());
        if (m_pend) exp_q.push_back({m_pend_pc, mem_word(m_pend_pc)});
      end
      m_pend = m_acc;
      if (m_acc) m_pend_pc = pc;
    end
    @(posedge clk);
    resp_v    = m_acc;
    resp_data = mem_word(pc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 32'h40);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    clr_n = 1'b1;
  endtask

  logic [ADDR_W-1:0] pc;

  initial begin
    clr_n       = 1'b0;
    flush       = 1'b0;
    i_pc        = '0;
    i_instr_req = 1'b0;
    i_de_ready  = 1'b0;
    i_mem_rdata = '0;
    resp_v      = 1'b0;
    resp_data   = '0;
    m_pend      = 1'b0;
    m_pend_pc   = '0;
    m_acc       = 1'b0;
    @(negedge clk);
    do_reset();

    // streaming with decode always ready
    pc = '0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 1'b0, pc);
      if (m_acc) pc += 4;
    end
    check("stream_no_stall", 64'(o_stall), 64'(0));

    // backpressure, then drain
    do_reset();
    pc = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, pc);
      if (m_acc) pc += 4;
    end
    check("bp_accepted", 64'(pc), 64'(16));
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, pc);
      if (m_acc) pc += 4;
    end

    // flush with queue {0,4} and pc 8 in flight; branch target 0x100
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h4);
    cycle(1'b1, 1'b0, 1'b0, 32'h8);
    check("flush_pre_valid", 64'(o_valid), 64'(1));
    cycle(1'b1, 1'b1, 1'b1, 32'h100);
    cycle(1'b0, 1'b0, 1'b0, 32'h104);
    check("flush_target_pc", 64'(o_pc), 64'(32'h100));
    cycle(1'b0, 1'b1, 1'b0, 32'h104);

    // three entries held, then simultaneous enqueue/dequeue across the wrap
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h10);
    cycle(1'b1, 1'b0, 1'b0, 32'h14);
    cycle(1'b1, 1'b0, 1'b0, 32'h18);
    cycle(1'b1, 1'b0, 1'b0, 32'h1c);
    cycle(1'b0, 1'b1, 1'b0, 32'h20);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 32'h20);

    // async reset between edges with entries buffered and one in flight
    cycle(1'b1, 1'b0, 1'b0, 32'h200);
    cycle(1'b1, 1'b0, 1'b0, 32'h204);
    cycle(1'b1, 1'b0, 1'b0, 32'h208);
    #2 clr_n = 1'b0;
    #1;
    check("arst_valid", 64'(o_valid), 64'(0));
    check("arst_stall", 64'(o_stall), 64'(0));
    check("arst_pc",    64'(o_pc),    64'(0));
    check("arst_instr", 64'(o_instr), 64'(0));
    @(negedge clk);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // randomized traffic with flushes and occasional resets
    pc = 32'h1000;
    for (int i = 0; i < 1500; i++) begin
      logic req, rdy, fl;
      req = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 99) < 8);
      if (fl) pc = {$urandom_range(0, 16'hffff), 2'b00};
      if ($urandom_range(0, 299) == 0) clr_n = 1'b0;
      cycle(req, rdy, fl, pc);
      clr_n = 1'b1;
      if (m_acc) pc += 4;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and decode.
- Accepts the fetch PC and request each cycle and issues it to a fixed-latency (1-cycle) synchronous instruction memory.
- Captures the returned instruction with its PC in a small FIFO and presents {pc, instr} to decode with a valid/ready handshake.
- Generates the fetch stall for backpressure and drops all buffered and in-flight instructions on a branch flush.

Parameters:
- ADDR_W, 32, PC / address width (matches `ADDR_W).
- INSTR_W, 32, instruction width (matches `INSTR_W).
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state on posedge.
- clr_n  input  1  asynchronous active-low reset.
- flush  input  1  branch taken this cycle; discard buffered and in-flight entries.
- i_pc  input  ADDR_W  fetch PC of the current request.
- i_instr_req  input  1  fetch requests i_pc this cycle.
- o_mem_addr  output  ADDR_W  instruction memory address (= i_pc).
- o_mem_en  output  1  memory read enable (= accepted request).
- i_mem_rdata  input  INSTR_W  memory data; valid the cycle after o_mem_en.
- o_stall  output  1  to fetch stall; request not accepted this cycle.
- o_valid  output  1  decode-side entry valid.
- o_pc  output  ADDR_W  PC of head entry.
- o_instr  output  INSTR_W  instruction of head entry.
- i_de_ready  input  1  decode consumes head when o_valid && i_de_ready.

Behaviour:
- **Reset** (clr_n low, async):
  - count, rd_ptr, wr_ptr = 0; pend = 0; pend_pc = 0.
  - Outputs: o_valid = 0, o_stall = 0, o_mem_en = 0, o_pc = 0, o_instr = 0.
  - Storage array is not reset.
- **Stall:** o_stall = (count + pend) >= DEPTH.
  - Uses registered state only; no path from i_de_ready or i_mem_rdata.
- **Accept:** acc = i_instr_req && !o_stall.
  - o_mem_en = acc; o_mem_addr = i_pc (combinational pass-through).
- **In-flight tracking:**
  - On each edge: pend <= acc; pend_pc <= i_pc when acc.
  - The request accepted in a flush cycle is the branch target and is kept.
- **Enqueue:** at edge ending cycle N+1 when pend && !flush.
  - Write {pend_pc, i_mem_rdata} at wr_ptr; wr_ptr += 1 (mod DEPTH).
  - If flush is high in N+1, the returning data is discarded.
- **Dequeue:** deq = o_valid && i_de_ready; rd_ptr += 1 (mod DEPTH).
- **Outputs:**
  - o_valid = (count != 0) && !flush.
  - o_pc / o_instr = head entry when o_valid, else 0.
- **Count update:**
  - count += enq − deq.
  - Simultaneous enqueue and dequeue leaves count unchanged, including at count == DEPTH−1 and count == 1.
- **Flush** (synchronous, highest priority):
  - count, rd_ptr, wr_ptr <= 0.
  - Enqueue of the current response is suppressed.
  - i_de_ready is ignored that cycle.
  - pend <= acc, so the branch-target fetch survives.
- **Latency:** request accepted in cycle N -> o_valid in cycle N+2 when the queue was empty. Sustained throughput is 1 instruction/cycle with decode ready.
- **Full condition:** the stall accounting reserves a slot for the pending response, so the FIFO never overflows. Enqueue when count == DEPTH is unreachable; assert it in simulation.
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap naturally.
- **Reset mid-operation:** all state clears immediately; the in-flight response is dropped.

Test Plan:
- **Streaming:** reset, then i_instr_req=1 with pc 0,4,8,… and i_de_ready=1 -> o_valid from cycle 2; o_pc 0,4,8 on consecutive cycles with matching rdata; o_stall stays 0.
- **Backpressure:** i_de_ready=0, requests continuous -> accept pc 0,4,8,12; o_stall=1 once count+pend=4; no 5th o_mem_en; release ready -> entries drain in order 0,4,8,12, then fetch resumes at 16.
- **Flush:** queue holds pc 0,4 with pending 8; flush=1 with i_pc=0x100 accepted -> next cycle o_valid=0, count=0; following cycle o_pc=0x100; pc 8 is never presented.
- **Simultaneous enq/deq at DEPTH−1:** hold 3 entries, then enqueue and dequeue in the same cycle -> count stays 3; order preserved across the wr_ptr wrap 3->0.
- **Async reset mid-stream:** drop clr_n between clock edges with 2 entries buffered -> o_valid, o_stall, o_pc, o_instr go to 0 immediately, without waiting for an edge; the pending response is not enqueued after release.
- **Flush while consuming:** flush with o_valid=1 and i_de_ready=1 -> o_valid reads 0 in that cycle and the head is not consumed; count=0 next cycle.
